// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the fetch stage and its PC unit:
//   WORD_W           - datapath word width (32)
//   RESET_PC_DEFAULT - default byte address of the first fetch
//   NOP_INSTR        - encoding used for a squashed (bubble) IF/ID slot
//   fetch_state_e    - fetch FSM state encoding (BOOT, RUN)
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int              WORD_W           = 32;
    localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // A redirect target is misaligned when its two low bits are not zero.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter register and next-PC mux for the fetch stage.
// Priority: rst > load (redirect) > advance (pc + 4) > hold.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   advance    - step pc by 4 this cycle
//   load       - load pc from load_word (word-aligned redirect target)
//   load_word  - redirect target word address (byte address bits [31:2])
//   addr       - low 16 bits of pc, the instruction-memory byte address
//   pc_plus4   - pc + 4 (modulo 2^32)
// ---------------------------------------------------------------------------
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              load,
    input  logic [29:0]       load_word,
    output logic [15:0]       addr,
    output logic [WORD_W-1:0] pc_plus4
);

    logic [WORD_W-1:0] pc_r;
    logic [WORD_W-1:0] pc_next_s;

    // Adder wraps naturally at 2^32.
    assign pc_plus4 = pc_r + 32'd4;
    // Addresses at or above 64 KB alias into the instruction memory.
    assign addr     = pc_r[15:0];

    // Next-PC selection.
    always_comb begin
        pc_next_s = pc_r;
        if (load) begin
            pc_next_s = {load_word, 2'b00};
        end else if (advance) begin
            pc_next_s = pc_plus4;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the BOOT/RUN FSM and the IF/ID pipeline
// register; the PC lives in pc_unit. A redirect squashes the wrong-path
// fetch (no delay slot) and wins over stall.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt/squash_cnt.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   stall        - hold PC and IF/ID outputs
//   redirect_en  - taken branch/jump from a later stage
//   redirect_pc  - redirect target byte address
//   im_addr      - instruction-memory byte address (pc[15:0])
//   im_ir        - combinational instruction-memory read data
//   id_ir        - registered instruction for decode
//   id_pc4       - registered PC+4 of id_ir
//   id_valid     - id_ir is a real instruction
//   fetch_err    - sticky misaligned-redirect flag
//   fetch_cnt    - (FETCH_PERF_CNT_EN) count of valid IF/ID loads
//   squash_cnt   - (FETCH_PERF_CNT_EN) count of squashing redirects
// ---------------------------------------------------------------------------
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [15:0]       im_addr,
    input  logic [WORD_W-1:0] im_ir,
    output logic [WORD_W-1:0] id_ir,
    output logic [WORD_W-1:0] id_pc4,
    output logic              id_valid,
    output logic              fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       squash_cnt
`endif
);

    fetch_state_e      state_r;
    logic [WORD_W-1:0] id_ir_r;
    logic [WORD_W-1:0] id_pc4_r;
    logic              id_valid_r;
    logic              fetch_err_r;
    logic [WORD_W-1:0] pc_plus4_s;
    logic              advance_s;
    logic              squash_s;

    // Advance only in RUN, unstalled, and not redirected; squash on a RUN redirect.
    always_comb begin
        advance_s = 1'b0;
        squash_s  = 1'b0;
        if (state_r == RUN) begin
            advance_s = ~stall & ~redirect_en;
            squash_s  = redirect_en;
        end else begin
            advance_s = 1'b0;
            squash_s  = 1'b0;
        end
    end

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance_s),
        .load      (redirect_en),
        .load_word (redirect_pc[31:2]),
        .addr      (im_addr),
        .pc_plus4  (pc_plus4_s)
    );

    // FSM, IF/ID register and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= BOOT;
            id_ir_r     <= NOP_INSTR;
            id_pc4_r    <= 32'h0000_0000;
            id_valid_r  <= 1'b0;
            fetch_err_r <= 1'b0;
        end else begin
            if (redirect_en && is_misaligned(redirect_pc)) begin
                fetch_err_r <= 1'b1;
            end else begin
                fetch_err_r <= fetch_err_r;
            end

            case (state_r)
                BOOT: begin
                    // One settle cycle; nothing has been fetched yet.
                    state_r    <= RUN;
                    id_ir_r    <= NOP_INSTR;
                    id_valid_r <= 1'b0;
                end
                RUN: begin
                    if (redirect_en) begin
                        // Wrong-path fetch becomes a bubble; id_pc4 keeps its value.
                        id_ir_r    <= NOP_INSTR;
                        id_valid_r <= 1'b0;
                    end else if (!stall) begin
                        id_ir_r    <= im_ir;
                        id_pc4_r   <= pc_plus4_s;
                        id_valid_r <= 1'b1;
                    end else begin
                        id_ir_r    <= id_ir_r;
                        id_pc4_r   <= id_pc4_r;
                        id_valid_r <= id_valid_r;
                    end
                end
                default: begin
                    state_r    <= BOOT;
                    id_ir_r    <= NOP_INSTR;
                    id_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign id_ir     = id_ir_r;
    assign id_pc4    = id_pc4_r;
    assign id_valid  = id_valid_r;
    assign fetch_err = fetch_err_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] squash_cnt_r;

    // Performance counters; both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r  <= 32'd0;
            squash_cnt_r <= 32'd0;
        end else begin
            if (advance_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
            if (squash_s) begin
                squash_cnt_r <= squash_cnt_r + 32'd1;
            end else begin
                squash_cnt_r <= squash_cnt_r;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_r;
    assign squash_cnt = squash_cnt_r;
`endif

endmodule
